// File: rtl/seg_pkg.sv
// seg_pkg
// Shared definitions for the seven-segment reader: the sixteen active-low
// segment codes (bit order g..a, bit0 = segment a), the all-off blank code,
// and the reader FSM state type.
package seg_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // IDLE: nothing pending; SETTLE: new pattern is being timed for stability;
  // PRESENT: a decoded digit is offered to the consumer.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_PRESENT = 2'd2
  } state_t;

endpackage

// File: rtl/seven_seg_reader_if.sv
// seven_seg_reader_if
// Output side of the seven-segment reader: a valid/ready handshake carrying
// the decoded digit and error flag, plus the dropped-pattern counter.
//   out_ready : consumer -> reader, accepts the offered digit
//   out_valid : reader -> consumer, digit/err are valid
//   out_digit : decoded hex value
//   out_err   : pattern was not a legal code
//   lost_cnt  : saturating count of patterns dropped while busy
interface seven_seg_reader_if;
  logic       out_ready;
  logic       out_valid;
  logic [3:0] out_digit;
  logic       out_err;
  logic [7:0] lost_cnt;

  modport master (
    input  out_ready,
    output out_valid,
    output out_digit,
    output out_err,
    output lost_cnt
  );

  modport slave (
    output out_ready,
    input  out_valid,
    input  out_digit,
    input  out_err,
    input  lost_cnt
  );
endinterface

// File: rtl/seven_seg_decode.sv
// seven_seg_decode
// Purely combinational decode of an active-low seven-segment pattern.
//   pat_i   : segment pattern, bit0 = a .. bit6 = g, active-low
//   digit_o : hex value 0..F for a legal code, 0 otherwise
//   err_o   : high when pat_i is none of the sixteen legal codes
module seven_seg_decode
  import seg_pkg::*;
(
  input  logic [6:0] pat_i,
  output logic [3:0] digit_o,
  output logic       err_o
);

  // Table lookup; anything outside the table (blank included) is an error.
  always_comb begin
    digit_o = 4'h0;
    err_o   = 1'b0;
    case (pat_i)
      SEG_0:   digit_o = 4'h0;
      SEG_1:   digit_o = 4'h1;
      SEG_2:   digit_o = 4'h2;
      SEG_3:   digit_o = 4'h3;
      SEG_4:   digit_o = 4'h4;
      SEG_5:   digit_o = 4'h5;
      SEG_6:   digit_o = 4'h6;
      SEG_7:   digit_o = 4'h7;
      SEG_8:   digit_o = 4'h8;
      SEG_9:   digit_o = 4'h9;
      SEG_A:   digit_o = 4'hA;
      SEG_B:   digit_o = 4'hB;
      SEG_C:   digit_o = 4'hC;
      SEG_D:   digit_o = 4'hD;
      SEG_E:   digit_o = 4'hE;
      SEG_F:   digit_o = 4'hF;
      default: begin
        digit_o = 4'h0;
        err_o   = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/seven_seg_reader.sv
// seven_seg_reader
// Samples an asynchronous active-low seven-segment pattern, waits until it
// has been stable for STABLE_CYCLES synchronized samples, decodes it and
// offers the result over a valid/ready handshake. Patterns that become
// stable while a previous result is still unacknowledged are counted in
// lost_cnt. The blank pattern is never reported but re-arms reporting of a
// repeated digit.
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   seg_in : raw segment pattern, asynchronous to clk
//   bus    : handshake/result interface (master side)
module seven_seg_reader
  import seg_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [6:0]                seg_in,
  seven_seg_reader_if.master        bus
);

  localparam logic [3:0] STABLE_C = 4'(STABLE_CYCLES);
  localparam logic [3:0] REACH_C  = 4'(STABLE_CYCLES - 1);

  logic [6:0] s1_q, s2_q, s2_prev_q;
  logic [3:0] cnt_q, cnt_d;
  state_t     state_q, state_d;
  logic [6:0] last_q, last_d;   // last reported (or blank) pattern
  logic [6:0] acc_q, acc_d;     // most recently accepted pattern
  logic [6:0] pres_q, pres_d;   // pattern currently being presented
  logic       out_valid_q, out_valid_d;
  logic [3:0] out_digit_q, out_digit_d;
  logic       out_err_q, out_err_d;
  logic [7:0] lost_q, lost_d;

  logic       changed_s, reach_s, accept_s, blank_s, hs_s, new_pres_s;
  logic [6:0] cmp_pat_s;
  logic [3:0] dec_digit_s;
  logic       dec_err_s;

  seven_seg_decode u_decode (
    .pat_i   (s2_q),
    .digit_o (dec_digit_s),
    .err_o   (dec_err_s)
  );

  assign changed_s = (s2_q != s2_prev_q);
  // Acceptance is the single cycle in which the counter steps onto STABLE.
  assign reach_s   = !changed_s && (cnt_q == REACH_C);
  // While presenting, compare with the latest accepted pattern so a quick
  // return to an older value is still seen as a new pattern.
  assign cmp_pat_s = (state_q == ST_PRESENT) ? acc_q : last_q;
  assign accept_s  = reach_s && (s2_q != cmp_pat_s);
  assign blank_s   = (s2_q == SEG_BLANK);
  assign hs_s      = out_valid_q && bus.out_ready;
  // A reportable acceptance: non-blank, and not a repeat of what is on the bus.
  assign new_pres_s = accept_s && !blank_s &&
                      ((state_q != ST_PRESENT) || (s2_q != pres_q));

  // Stability counter: restart on any change of s2, saturate at STABLE.
  always_comb begin
    cnt_d = cnt_q;
    if (changed_s) begin
      cnt_d = 4'd0;
    end else if (cnt_q != STABLE_C) begin
      cnt_d = cnt_q + 4'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Two-flop synchronizer, delayed s2 copy and stability counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q      <= SEG_BLANK;
      s2_q      <= SEG_BLANK;
      s2_prev_q <= SEG_BLANK;
      cnt_q     <= 4'd0;
    end else begin
      s1_q      <= seg_in;
      s2_q      <= s1_q;
      s2_prev_q <= s2_q;
      cnt_q     <= cnt_d;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (s2_q != last_q) begin
          state_d = ST_SETTLE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (new_pres_s) begin
          state_d = ST_PRESENT;
        end else if (accept_s || (s2_q == last_q)) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_SETTLE;
        end
      end
      ST_PRESENT: begin
        if (hs_s && !new_pres_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_PRESENT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM output/datapath next values.
  always_comb begin
    last_d      = last_q;
    acc_d       = accept_s ? s2_q : acc_q;
    pres_d      = pres_q;
    out_digit_d = out_digit_q;
    out_err_d   = out_err_q;
    lost_d      = lost_q;
    out_valid_d = (state_d == ST_PRESENT);
    case (state_q)
      ST_IDLE: begin
        last_d = last_q;
      end
      ST_SETTLE: begin
        if (new_pres_s) begin
          pres_d      = s2_q;
          out_digit_d = dec_digit_s;
          out_err_d   = dec_err_s;
        end else if (accept_s) begin
          // Only blank gets here: remember it so a repeat is reported again.
          last_d = SEG_BLANK;
        end else begin
          last_d = last_q;
        end
      end
      ST_PRESENT: begin
        if (hs_s && new_pres_s) begin
          // Handshake and new acceptance together: retire, then load new.
          last_d      = pres_q;
          pres_d      = s2_q;
          out_digit_d = dec_digit_s;
          out_err_d   = dec_err_s;
        end else if (hs_s) begin
          // Anything accepted while busy is treated as already seen.
          last_d = acc_d;
        end else if (new_pres_s && (lost_q != 8'hFF)) begin
          lost_d = lost_q + 8'd1;
        end else begin
          lost_d = lost_q;
        end
      end
      default: begin
        last_d = last_q;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q      <= SEG_BLANK;
      acc_q       <= SEG_BLANK;
      pres_q      <= SEG_BLANK;
      out_valid_q <= 1'b0;
      out_digit_q <= 4'h0;
      out_err_q   <= 1'b0;
      lost_q      <= 8'd0;
    end else begin
      last_q      <= last_d;
      acc_q       <= acc_d;
      pres_q      <= pres_d;
      out_valid_q <= out_valid_d;
      out_digit_q <= out_digit_d;
      out_err_q   <= out_err_d;
      lost_q      <= lost_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_digit = out_digit_q;
  assign bus.out_err   = out_err_q;
  assign bus.lost_cnt  = lost_q;

endmodule

// File: doc/seven_seg_reader.md
SEVEN_SEG_READER -- requirements
Module: seven_seg_reader

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, meaning consecutive identical synchronized samples required before a pattern is accepted (legal range 1..15).
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 seg_in  input  7  active-low segment pattern, bit0=a through bit6=g; asynchronous to clk.
REQ-005 out_ready  input  1  consumer accepts out_digit/out_err when high with out_valid high.
REQ-006 out_valid  output  1  decoded digit available.
REQ-007 out_digit  output  4  decoded hex value 0..F.
REQ-008 out_err  output  1  presented pattern is not one of the 16 legal codes.
REQ-009 lost_cnt  output  8  saturating count of accepted patterns dropped while a previous one was unacknowledged.

Function
REQ-010 seg_in SHALL pass through a two-flop synchronizer; all later logic uses the second stage (s2).
REQ-011 A stability counter SHALL reset to 0 whenever s2 differs from its value one cycle earlier, otherwise increment, saturating at STABLE_CYCLES.
REQ-012 A pattern SHALL be accepted in the cycle the counter reaches STABLE_CYCLES, and only if it differs from last_pat (last reported pattern).
REQ-013 Decode table (active-low, g..a): 0=1000000 1=1111001 2=0100100 3=0110000 4=0011001 5=0010010 6=0000010 7=1111000 8=0000000 9=0010000 A=0001000 b=0000011 C=1000110 d=0100001 E=0000110 F=0001110.
REQ-014 Accepted legal pattern: out_digit = table value, out_err = 0; accepted illegal pattern: out_digit = 0, out_err = 1.
REQ-015 Blank pattern 1111111 SHALL never be reported; its acceptance sets last_pat to blank so a repeat of the previous digit is reported again.
REQ-016 FSM states: IDLE (no change pending), SETTLE (s2 differs from last_pat, counting), PRESENT (out_valid = 1).
REQ-017 IDLE -> SETTLE when s2 != last_pat; SETTLE -> IDLE if s2 returns to last_pat or blank is accepted; SETTLE -> PRESENT on acceptance.
REQ-018 PRESENT -> IDLE on out_valid & out_ready, updating last_pat in that cycle; out_digit/out_err SHALL stay constant while in PRESENT.
REQ-019 Acceptance of a different non-blank pattern while in PRESENT without handshake SHALL increment lost_cnt (saturate at 255) and leave outputs unchanged.
REQ-020 Acceptance and handshake in the same cycle: handshake completes, new pattern enters PRESENT next cycle (no loss).
REQ-021 Latency: seg_in change stable from cycle 0 -> out_valid high at cycle STABLE_CYCLES + 3 (default 7).
REQ-022 out_valid SHALL be driven only from registers.

Reset
REQ-023 On rst_n low: out_valid = 0, out_digit = 0, out_err = 0, lost_cnt = 0, FSM = IDLE, counter = 0, synchronizer and last_pat = 1111111.
REQ-024 Reset mid-PRESENT SHALL drop the pending digit without incrementing lost_cnt; the stable input is re-reported after REQ-021 latency once rst_n rises.

Structure
REQ-025 Package seg_pkg SHALL hold the 16 segment-code constants, the blank constant, and the FSM state typedef.
REQ-026 Decode SHALL be a combinational sub-module seven_seg_decode (pattern in -> digit, err out); seven_seg_reader instantiates it once.

Verification
REQ-027 seg_in=1111001 held 20 cycles, out_ready=1 -> single out_valid pulse at cycle 7, out_digit=1, out_err=0.
REQ-028 seg_in=0100100 for 3 cycles then back to previous digit -> no out_valid.
REQ-029 seg_in=1010101 stable -> out_valid, out_err=1, out_digit=0.
REQ-030 out_ready=0, digit 7 presented, then 0000000 stable -> out_digit stays 7, lost_cnt=1; 300 such drops -> lost_cnt=255.
REQ-031 digit 5, blank 10 cycles, digit 5 again, out_ready=1 -> two out_valid pulses, both out_digit=5.
REQ-032 rst_n low while out_valid=1 -> all outputs 0 asynchronously; steady input re-reported 7 cycles after release.
